// File: rtl/dmem_lat.sv
// dmem_lat: byte-masked word RAM behind a request/valid handshake with
// independent, parameterised read and write latency.
// Optional fault checking (out-of-range / misaligned) is compiled in when the
// macro DMEM_LAT_FAULT_EN is defined; otherwise addresses wrap and err is 0.
module dmem_lat #(
  parameter int SIZE_IN_BYTES = 64,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_from_dmem,
  output logic        op_data_busy,
  output logic        op_data_err
);

  localparam int         AW     = $clog2(SIZE_IN_BYTES);
  localparam int         DEPTH  = SIZE_IN_BYTES / 4;
  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        is_wr_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  logic        req;
  logic [3:0]  req_lat;

  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_mask;
  logic        acc_wr;
  logic [AW-3:0] acc_idx;
  logic        commit;
  logic        fault;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  lane_we;

  // A write wins over a simultaneous read, so its latency is the one used.
  assign req     = ip_data_wr | ip_data_rd;
  assign req_lat = ip_data_wr ? WR_LAT : RD_LAT;

  // State register and latency counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept only in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_lat == 4'd1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = req_lat - 4'd1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    op_data_valid = (state_q == S_RESP);
    op_data_busy  = (state_q != S_IDLE);
  end

  assign op_data_from_dmem = rdata_q;

  // Capture the request on acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      is_wr_q <= 1'b0;
    end else if (state_q == S_IDLE && req) begin
      addr_q  <= ip_data_addr;
      wdata_q <= ip_data_from_proc;
      mask_q  <= ip_data_mask;
      is_wr_q <= ip_data_wr;
    end
  end

  // With latency 1 the access happens on the accepting edge itself, so the
  // live inputs are used while in IDLE and the captured copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = ip_data_addr;
      acc_wdata = ip_data_from_proc;
      acc_mask  = ip_data_mask;
      acc_wr    = ip_data_wr;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_mask  = mask_q;
      acc_wr    = is_wr_q;
    end
  end

  assign acc_idx = acc_addr[AW-1:2];
  assign commit  = (state_d == S_RESP);

`ifdef DMEM_LAT_FAULT_EN
  logic oob;
  logic misalign;
  logic err_q;

  // Fault classification: out of range, or low address bits misaligned to the mask.
  always_comb begin
    oob      = (acc_addr >= 32'(SIZE_IN_BYTES));
    misalign = 1'b0;
    case (acc_mask)
      4'b1111:          misalign = |acc_addr[1:0];
      4'b0011, 4'b1100: misalign = acc_addr[0];
      default:          misalign = 1'b0;
    endcase
  end

  assign fault = oob | misalign;

  // Fault flag latched alongside the access, shown only during RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    err_q <= 1'b0;
    else if (commit) err_q <= fault;
  end

  assign op_data_err = err_q & (state_q == S_RESP);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:AW], acc_addr[1:0]};
  assign fault            = 1'b0;
  assign op_data_err      = 1'b0;
`endif

  assign wr_en = commit & acc_wr & ~fault;
  assign rd_en = commit & ~acc_wr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = wr_en & acc_mask[gi];
    end
  endgenerate

  // Byte-masked write port; contents are never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
    end
  end

  // Registered read port; holds its value until the next read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rdata_q <= '0;
    else if (rd_en) rdata_q <= fault ? 32'h0 : mem[acc_idx];
  end

endmodule

// File: tb/tb_dmem_lat.sv
// tb_dmem_lat: table vectors, hand sequences for reset/hold/back-to-back, and
// random accesses checked against a word-array reference model.
module tb_dmem_lat;

  localparam int SIZE = 64;
  localparam int RL   = 3;
  localparam int WL   = 2;

  logic        clk;
  logic        reset_n;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_data_valid;
  logic [31:0] op_data_from_dmem;
  logic        op_data_busy;
  logic        op_data_err;

  dmem_lat #(
    .SIZE_IN_BYTES(SIZE),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ip_data_addr     (ip_data_addr),
    .ip_data_wr       (ip_data_wr),
    .ip_data_mask     (ip_data_mask),
    .ip_data_from_proc(ip_data_from_proc),
    .ip_data_rd       (ip_data_rd),
    .op_data_valid    (op_data_valid),
    .op_data_from_dmem(op_data_from_dmem),
    .op_data_busy     (op_data_busy),
    .op_data_err      (op_data_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [SIZE/4];
  logic [31:0] model_last;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit model_fault(input logic [31:0] a, input logic [3:0] m);
`ifdef DMEM_LAT_FAULT_EN
    if (a >= SIZE) return 1'b1;
    if (m == 4'hF && (a % 4) != 0) return 1'b1;
    if ((m == 4'h3 || m == 4'hC) && (a % 2) != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour: write wins, addresses taken modulo SIZE, faults suppress.
  task automatic model_apply(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] wdata,
                             output logic [31:0] exp_data, output logic exp_err,
                             output int exp_lat);
    int  w;
    bit  f;
    w = (addr % SIZE) / 4;
    f = model_fault(addr, mask);
    if (wr) begin
      exp_lat = WL;
      if (!f) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
      end
    end else begin
      exp_lat    = RL;
      model_last = f ? 32'h0 : model_mem[w];
    end
    if (!wr && !rd) exp_lat = 0;
    exp_data = model_last;
    exp_err  = f;
  endtask

  task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] wdata,
                           output logic [31:0] data, output logic err, output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    lat     = 0;
    data    = 'x;
    err     = 'x;
    @(negedge clk);
    ip_data_wr        = wr;
    ip_data_rd        = rd;
    ip_data_addr      = addr;
    ip_data_mask      = mask;
    ip_data_from_proc = wdata;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!op_data_busy) busy_ok = 1'b0;
      if (op_data_valid) begin
        lat  = k;
        data = op_data_from_dmem;
        err  = op_data_err;
        break;
      end
    end
    ip_data_wr = 1'b0;
    ip_data_rd = 1'b0;
    @(negedge clk);
    check("busy_during_access", 32'(busy_ok), 32'd1);
    check("valid_single_pulse", {31'd0, op_data_valid}, 32'd0);
    $display("txn wr=%0d rd=%0d addr=%h mask=%b wdata=%h -> data=%h err=%0d lat=%0d",
             wr, rd, addr, mask, wdata, data, err, lat);
  endtask

  task automatic model_access(input string tag, input bit wr, input bit rd,
                              input logic [31:0] addr, input logic [3:0] mask,
                              input logic [31:0] wdata);
    logic [31:0] got_d, exp_d;
    logic        got_e, exp_e;
    int          got_l, exp_l;
    model_apply(wr, rd, addr, mask, wdata, exp_d, exp_e, exp_l);
    do_access(wr, rd, addr, mask, wdata, got_d, got_e, got_l);
    check({tag, "_lat"},  32'(got_l), 32'(exp_l));
    check({tag, "_data"}, got_d, exp_d);
    check({tag, "_err"},  {31'd0, got_e}, {31'd0, exp_e});
  endtask

  initial begin
    logic [31:0] d, ed;
    logic        e, ee;
    int          l, el;
    int          vpos [$];

    reset_n = 1'b0;
    ip_data_addr = '0; ip_data_wr = 1'b0; ip_data_mask = '0;
    ip_data_from_proc = '0; ip_data_rd = 1'b0;
    model_last = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'd0, op_data_valid}, 32'd0);
    check("reset_busy",  {31'd0, op_data_busy},  32'd0);
    check("reset_data",  op_data_from_dmem,       32'd0);
    check("reset_err",   {31'd0, op_data_err},   32'd0);
    reset_n = 1'b1;

    // Preload every word through the port so the model knows all contents.
    for (int w = 0; w < SIZE/4; w++)
      model_access("preload", 1'b1, 1'b0, 32'(w*4), 4'hF, $urandom);
    model_access("preload0", 1'b1, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF);
    model_access("preload1", 1'b1, 1'b0, 32'h4, 4'hF, 32'h12345678);

    vecs[0]  = '{0, 1, 32'h04, 4'hF, 32'h0,        32'h12345678, 0, RL};
    vecs[1]  = '{1, 0, 32'h08, 4'hF, 32'hAABBCCDD, 32'h12345678, 0, WL};
    vecs[2]  = '{1, 0, 32'h08, 4'h5, 32'h11223344, 32'h12345678, 0, WL};
    vecs[3]  = '{0, 1, 32'h08, 4'hF, 32'h0,        32'hAA22CC44, 0, RL};
    vecs[4]  = '{1, 0, 32'h00, 4'h0, 32'hFFFFFFFF, 32'hAA22CC44, 0, WL};
    vecs[5]  = '{0, 1, 32'h00, 4'hF, 32'h0,        32'hDEADBEEF, 0, RL};
    vecs[6]  = '{1, 0, 32'h04, 4'h8, 32'h77000000, 32'hDEADBEEF, 0, WL};
    vecs[7]  = '{0, 1, 32'h04, 4'hF, 32'h0,        32'h77345678, 0, RL};
    vecs[8]  = '{1, 0, 32'h14, 4'hF, 32'h01020304, 32'h77345678, 0, WL};
    vecs[9]  = '{1, 0, 32'h14, 4'h3, 32'h9999ABCD, 32'h77345678, 0, WL};
    vecs[10] = '{0, 1, 32'h14, 4'hF, 32'h0,        32'h0102ABCD, 0, RL};

    for (int i = 0; i < 11; i++) begin
      model_apply(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].mask, vecs[i].wdata, ed, ee, el);
      do_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].mask, vecs[i].wdata, d, e, l);
      check($sformatf("vec%0d_lat", i),  32'(l), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i),  {31'd0, e}, {31'd0, vecs[i].exp_err});
    end

    // Reset in the middle of a write's WAIT: aborted, never committed.
    @(negedge clk);
    ip_data_wr = 1'b1; ip_data_addr = 32'h0; ip_data_mask = 4'hF; ip_data_from_proc = 32'h0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_valid", {31'd0, op_data_valid}, 32'd0);
    check("midreset_busy",  {31'd0, op_data_busy},  32'd0);
    check("midreset_data",  op_data_from_dmem,       32'd0);
    check("midreset_err",   {31'd0, op_data_err},   32'd0);
    ip_data_wr = 1'b0;
    model_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_access(1'b0, 1'b1, 32'h0, 4'hF, 32'h0, d, e, l);
    check("midreset_mem0", d, 32'hDEADBEEF);
    model_last = d;

    // Collision: write wins; a different request during WAIT is ignored.
    model_apply(1'b1, 1'b1, 32'hC, 4'hF, 32'hCAFEF00D, ed, ee, el);
    @(negedge clk);
    ip_data_wr = 1'b1; ip_data_rd = 1'b1; ip_data_addr = 32'hC;
    ip_data_mask = 4'hF; ip_data_from_proc = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    ip_data_wr = 1'b1; ip_data_rd = 1'b0; ip_data_addr = 32'h10; ip_data_from_proc = 32'h0BADBAD0;
    l = 0;
    if (op_data_valid) l = 1;
    for (int k = 2; k <= 20 && l == 0; k++) begin
      @(negedge clk);
      if (op_data_valid) begin
        l = k;
        d = op_data_from_dmem;
      end
    end
    ip_data_wr = 1'b0;
    check("collision_lat",  32'(l), 32'(WL));
    check("collision_held", d, ed);
    @(negedge clk);
    check("collision_idle", {31'd0, op_data_busy}, 32'd0);
    $display("txn collision wr+rd addr=0000000c -> lat=%0d", l);
    model_access("collision_rd12", 1'b0, 1'b1, 32'hC, 4'hF, 32'h0);
    model_access("hold_rd16", 1'b0, 1'b1, 32'h10, 4'hF, 32'h0);

    // Held read request: responses every RL+1 cycles.
    @(negedge clk);
    ip_data_rd = 1'b1; ip_data_addr = 32'h8; ip_data_mask = 4'hF;
    @(posedge clk);
    for (int k = 1; k <= 2*RL+1; k++) begin
      @(negedge clk);
      if (op_data_valid) vpos.push_back(k);
      if (k == 2*RL+1) ip_data_rd = 1'b0;
    end
    @(negedge clk);
    check("b2b_count", 32'(vpos.size()), 32'd2);
    if (vpos.size() == 2) begin
      check("b2b_first",  32'(vpos[0]), 32'(RL));
      check("b2b_second", 32'(vpos[1]), 32'(2*RL+1));
    end
    check("b2b_idle", {31'd0, op_data_busy}, 32'd0);
    check("b2b_data", op_data_from_dmem, model_mem[2]);
    model_last = model_mem[2];
    $display("txn back-to-back rd addr=00000008 -> pulses=%0d", vpos.size());

`ifdef DMEM_LAT_FAULT_EN
    model_access("fault_rd40",  1'b0, 1'b1, 32'h40, 4'hF, 32'h0);
    model_access("fault_wr2",   1'b1, 1'b0, 32'h2,  4'hF, 32'h0);
    model_access("fault_rd0",   1'b0, 1'b1, 32'h0,  4'hF, 32'h0);
    check("fault_mem0", d, 32'hDEADBEEF);
`else
    model_access("wrap_wr44", 1'b1, 1'b0, 32'h44, 4'hF, 32'h55);
    model_access("wrap_rd4",  1'b0, 1'b1, 32'h4,  4'hF, 32'h0);
    check("wrap_mem1", model_last, 32'h55);
    model_access("wrap_rd47", 1'b0, 1'b1, 32'hFFFF_FF47, 4'hF, 32'h0);
`endif

    for (int i = 0; i < 80; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
`ifdef DMEM_LAT_FAULT_EN
      a = $urandom_range(0, 79);
`else
      a = $urandom;
`endif
      model_access($sformatf("rand%0d", i), op != 0, op != 1, a, 4'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
